// File: rtl/sha256_round_core.sv
// SHA-256 compression stage: accepts a 512-bit block, runs 64 rounds against an external
// message scheduler, then folds the working variables into the chained hash state.
module sha256_round_core #(
   parameter logic [255:0] SHA256_IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic [511:0] block_i,
   input  logic         first_blk_i,
   output logic [511:0] sched_block_o,
   output logic         sched_start_o,
   output logic         sched_advance_o,
   output logic [5:0]   sched_round_o,
   input  logic [31:0]  sched_word_i,
   output logic         busy_o,
   output logic         digest_valid_o,
   output logic [255:0] digest_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROUNDS,
      ST_FINAL
   } state_t;

   state_t        state_q, state_d;
   logic [255:0]  hash_q, hash_d;
   logic [255:0]  work_q, work_d;
   logic [5:0]    round_q, round_d;
   logic [511:0]  block_q, block_d;
   logic [255:0]  digest_q, digest_d;
   logic          digest_valid_q, digest_valid_d;

   logic          accept;
   logic [31:0]   wa, wb, wc, wd, we, wf, wg, wh;
   logic [31:0]   k_t, big_s1, ch, big_s0, maj, t1, t2;
   logic [255:0]  hash_sum;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] idx);
      logic [31:0] k;
      case (idx)
         6'd0:  k = 32'h428a2f98;
         6'd1:  k = 32'h71374491;
         6'd2:  k = 32'hb5c0fbcf;
         6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b;
         6'd5:  k = 32'h59f111f1;
         6'd6:  k = 32'h923f82a4;
         6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98;
         6'd9:  k = 32'h12835b01;
         6'd10: k = 32'h243185be;
         6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74;
         6'd13: k = 32'h80deb1fe;
         6'd14: k = 32'h9bdc06a7;
         6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1;
         6'd17: k = 32'hefbe4786;
         6'd18: k = 32'h0fc19dc6;
         6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f;
         6'd21: k = 32'h4a7484aa;
         6'd22: k = 32'h5cb0a9dc;
         6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152;
         6'd25: k = 32'ha831c66d;
         6'd26: k = 32'hb00327c8;
         6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3;
         6'd29: k = 32'hd5a79147;
         6'd30: k = 32'h06ca6351;
         6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85;
         6'd33: k = 32'h2e1b2138;
         6'd34: k = 32'h4d2c6dfc;
         6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354;
         6'd37: k = 32'h766a0abb;
         6'd38: k = 32'h81c2c92e;
         6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1;
         6'd41: k = 32'ha81a664b;
         6'd42: k = 32'hc24b8b70;
         6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819;
         6'd45: k = 32'hd6990624;
         6'd46: k = 32'hf40e3585;
         6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116;
         6'd49: k = 32'h1e376c08;
         6'd50: k = 32'h2748774c;
         6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3;
         6'd53: k = 32'h4ed8aa4a;
         6'd54: k = 32'h5b9cca4f;
         6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee;
         6'd57: k = 32'h78a5636f;
         6'd58: k = 32'h84c87814;
         6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa;
         6'd61: k = 32'ha4506ceb;
         6'd62: k = 32'hbef9a3f7;
         default: k = 32'hc67178f2;
      endcase
      return k;
   endfunction

   assign accept = blk_valid_i && (state_q == ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         hash_q         <= '0;
         work_q         <= '0;
         round_q        <= '0;
         block_q        <= '0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         hash_q         <= hash_d;
         work_q         <= work_d;
         round_q        <= round_d;
         block_q        <= block_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_ROUNDS;
         ST_ROUNDS: if (round_q == 6'd63) state_d = ST_FINAL;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      blk_ready_o     = 1'b0;
      busy_o          = 1'b1;
      sched_start_o   = 1'b0;
      sched_advance_o = 1'b0;
      sched_round_o   = '0;
      case (state_q)
         ST_IDLE: begin
            blk_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         ST_LOAD:   sched_start_o = 1'b1;
         ST_ROUNDS: begin
            sched_advance_o = 1'b1;
            sched_round_o   = round_q;
         end
         default: ;
      endcase
   end

   // Working variables are packed a..h with a in the top word, matching the H layout.
   always_comb begin
      {wa, wb, wc, wd, we, wf, wg, wh} = work_q;
      k_t    = k_rom(round_q);
      big_s1 = rotr(we, 6) ^ rotr(we, 11) ^ rotr(we, 25);
      ch     = (we & wf) ^ (~we & wg);
      big_s0 = rotr(wa, 2) ^ rotr(wa, 13) ^ rotr(wa, 22);
      maj    = (wa & wb) ^ (wa & wc) ^ (wb & wc);
      t1     = wh + big_s1 + ch + k_t + sched_word_i;
      t2     = big_s0 + maj;
      for (int i = 0; i < 8; i++) begin
         hash_sum[32*i +: 32] = hash_q[32*i +: 32] + work_q[32*i +: 32];
      end
   end

   always_comb begin
      hash_d         = hash_q;
      work_d         = work_q;
      round_d        = round_q;
      block_d        = block_q;
      digest_d       = digest_q;
      digest_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               block_d = block_i;
               if (first_blk_i) begin
                  hash_d = SHA256_IV;
                  work_d = SHA256_IV;
               end else begin
                  work_d = hash_q;
               end
            end
         end
         ST_LOAD: round_d = '0;
         ST_ROUNDS: begin
            work_d  = {t1 + t2, wa, wb, wc, wd + t1, we, wf, wg};
            round_d = round_q + 6'd1;
         end
         default: begin
            hash_d         = hash_sum;
            digest_d       = hash_sum;
            digest_valid_d = 1'b1;
         end
      endcase
   end

   assign sched_block_o  = block_q;
   assign digest_o       = digest_q;
   assign digest_valid_o = digest_valid_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// Bench for sha256_round_core: a behavioural message scheduler feeds W_t, and a scoreboard
// matches every digest pulse against known SHA-256 vectors, latency and scheduler controls.
module tb_sha256_round_core;

   localparam logic [511:0] BLK_ABC =
      {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY =
      {32'h80000000, {15{32'h0}}};
   localparam logic [511:0] BLK_2A =
      {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_2B =
      {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] DIG_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_2B =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic         clk_i;
   logic         rst_n;
   logic         blk_valid_i;
   logic         blk_ready_o;
   logic [511:0] block_i;
   logic         first_blk_i;
   logic [511:0] sched_block_o;
   logic         sched_start_o;
   logic         sched_advance_o;
   logic [5:0]   sched_round_o;
   logic [31:0]  sched_word_i;
   logic         busy_o;
   logic         digest_valid_o;
   logic [255:0] digest_o;

   typedef struct {
      logic [255:0] dig;
      logic         chk;
   } exp_t;

   exp_t sb[$];
   int   hsq[$];
   int   total;
   int   bad;
   int   cyc;
   int   start_cnt;
   int   adv_cnt;
   int   exp_round;
   logic prev_valid;
   logic [2047:0] wflat;

   sha256_round_core dut (
      .clk_i           (clk_i),
      .rst_n           (rst_n),
      .blk_valid_i     (blk_valid_i),
      .blk_ready_o     (blk_ready_o),
      .block_i         (block_i),
      .first_blk_i     (first_blk_i),
      .sched_block_o   (sched_block_o),
      .sched_start_o   (sched_start_o),
      .sched_advance_o (sched_advance_o),
      .sched_round_o   (sched_round_o),
      .sched_word_i    (sched_word_i),
      .busy_o          (busy_o),
      .digest_valid_o  (digest_valid_o),
      .digest_o        (digest_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Full 64-word expansion, W0 in the top word, as the upstream scheduler would produce.
   function automatic logic [2047:0] expand(input logic [511:0] blk);
      logic [31:0] w [64];
      logic [2047:0] flat;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      end
      for (int i = 0; i < 64; i++) flat[2047 - 32*i -: 32] = w[i];
      return flat;
   endfunction

   always @(posedge clk_i) begin
      if (sched_start_o) wflat <= expand(sched_block_o);
   end

   always_comb begin
      int idx;
      idx = int'(sched_round_o);
      sched_word_i = wflat[2047 - 32*idx -: 32];
   end

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic noteFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got timeout expected event", name);
   endtask

   task automatic applyStimulus(input logic [511:0] blk, input logic first,
                                input logic [255:0] exp_dig, input logic chk,
                                input logic push, input logic b2b);
      int   waited;
      logic saw_valid;
      exp_t e;
      blk_valid_i = 1'b1;
      block_i     = blk;
      first_blk_i = first;
      waited      = 0;
      @(negedge clk_i);
      while (!blk_ready_o && waited < 200) begin
         @(negedge clk_i);
         waited++;
      end
      if (!blk_ready_o) begin
         noteFail("handshake_wait");
         blk_valid_i = 1'b0;
         return;
      end
      saw_valid = digest_valid_o;
      if (push) begin
         e.dig = exp_dig;
         e.chk = chk;
         sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
      blk_valid_i = 1'b0;
      checkOutput("sched_block", sched_block_o, blk);
      if (b2b) checkOutput("b2b_accept_in_valid_cycle", {511'd0, saw_valid}, 512'd1);
   endtask

   task automatic waitIdle();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 500) begin
         @(posedge clk_i);
         waited++;
      end
      if (sb.size() != 0) noteFail("digest_wait");
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"}, {511'd0, blk_ready_o}, 512'd1);
      checkOutput({tag, "_busy"}, {511'd0, busy_o}, 512'd0);
      checkOutput({tag, "_valid"}, {511'd0, digest_valid_o}, 512'd0);
      checkOutput({tag, "_digest"}, {256'd0, digest_o}, 512'd0);
      checkOutput({tag, "_sched_block"}, sched_block_o, 512'd0);
      checkOutput({tag, "_sched_ctl"}, {504'd0, sched_start_o, sched_advance_o, sched_round_o}, 512'd0);
   endtask

   // Monitor: pops the scoreboard on each digest pulse and tracks scheduler handshakes.
   always @(negedge clk_i) begin
      if (!rst_n) begin
         hsq.delete();
         start_cnt  = 0;
         adv_cnt    = 0;
         exp_round  = 0;
         prev_valid = 1'b0;
      end else begin
         if (blk_valid_i && blk_ready_o) hsq.push_back(cyc);
         if (sched_start_o) start_cnt++;
         if (sched_advance_o) begin
            checkOutput("sched_round_step", {506'd0, sched_round_o}, 512'(exp_round));
            exp_round++;
            adv_cnt++;
         end else if (sched_round_o != 6'd0) begin
            checkOutput("sched_round_idle", {506'd0, sched_round_o}, 512'd0);
         end
         if (digest_valid_o) begin
            checkOutput("valid_one_cycle", {511'd0, prev_valid}, 512'd0);
            checkOutput("start_count", 512'(start_cnt), 512'd1);
            checkOutput("advance_count", 512'(adv_cnt), 512'd64);
            start_cnt = 0;
            adv_cnt   = 0;
            exp_round = 0;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_digest: got %0h expected none", digest_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.chk) checkOutput("digest", {256'd0, digest_o}, {256'd0, e.dig});
            end
            if (hsq.size() != 0) begin
               int c0;
               c0 = hsq.pop_front();
               checkOutput("latency", 512'(cyc - c0), 512'd67);
            end
         end
         prev_valid = digest_valid_o;
      end
   end

   initial begin
      total       = 0;
      bad         = 0;
      cyc         = 0;
      start_cnt   = 0;
      adv_cnt     = 0;
      exp_round   = 0;
      prev_valid  = 1'b0;
      wflat       = '0;
      rst_n       = 1'b0;
      blk_valid_i = 1'b0;
      block_i     = '0;
      first_blk_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checkResetOutputs("reset");
      @(negedge clk_i);
      rst_n = 1'b1;
      @(posedge clk_i);
      #1;

      $display("[TB] abc block");
      applyStimulus(BLK_ABC, 1'b1, DIG_ABC, 1'b1, 1'b1, 1'b0);
      waitIdle();
      checkOutput("abc_digest_hold", {256'd0, digest_o}, {256'd0, DIG_ABC});

      $display("[TB] empty message");
      applyStimulus(BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b1, 1'b1, 1'b0);
      waitIdle();

      $display("[TB] two-block chained message");
      applyStimulus(BLK_2A, 1'b1, 256'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(BLK_2B, 1'b0, DIG_2B, 1'b1, 1'b1, 1'b1);
      waitIdle();

      $display("[TB] valid held during rounds");
      applyStimulus(BLK_ABC, 1'b1, DIG_ABC, 1'b1, 1'b1, 1'b0);
      fork
         applyStimulus(BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b1, 1'b1, 1'b1);
         begin
            repeat (30) @(negedge clk_i);
            checkOutput("held_ready_low", {511'd0, blk_ready_o}, 512'd0);
            checkOutput("held_busy", {511'd0, busy_o}, 512'd1);
            checkOutput("held_digest_unchanged", {256'd0, digest_o}, {256'd0, DIG_2B});
         end
      join
      waitIdle();
      checkOutput("held_final_digest", {256'd0, digest_o}, {256'd0, DIG_EMPTY});

      $display("[TB] reset mid-block");
      applyStimulus(BLK_ABC, 1'b1, 256'd0, 1'b0, 1'b0, 1'b0);
      begin
         int waited;
         waited = 0;
         while (sched_round_o != 6'd30 && waited < 100) begin
            @(negedge clk_i);
            waited++;
         end
         if (sched_round_o != 6'd30) noteFail("round30_wait");
      end
      rst_n = 1'b0;
      #2;
      checkResetOutputs("midreset");
      @(posedge clk_i);
      #1;
      checkResetOutputs("midreset_edge");
      @(negedge clk_i);
      rst_n = 1'b1;
      repeat (80) @(posedge clk_i);
      #1;
      checkOutput("abort_no_digest", {256'd0, digest_o}, 512'd0);
      applyStimulus(BLK_ABC, 1'b1, DIG_ABC, 1'b1, 1'b1, 1'b0);
      waitIdle();
      checkOutput("resubmit_digest", {256'd0, digest_o}, {256'd0, DIG_ABC});
      checkOutput("scoreboard_empty", 512'(sb.size()), 512'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
